// File: rtl/rr_stream_merge.sv
`default_nettype none
// ============================================================================
//  Module   : rr_stream_merge
//  Brief    : Three-input round-robin merge onto one registered valid/ready
//             byte stream, tagged with source channel, with per-channel
//             wrapping accepted-byte counters.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_stream_merge #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch0_valid_i,
    output logic              ch0_ready_o,
    input  logic [DATA_W-1:0] ch0_data_i,
    input  logic              ch1_valid_i,
    output logic              ch1_ready_o,
    input  logic [DATA_W-1:0] ch1_data_i,
    input  logic              ch2_valid_i,
    output logic              ch2_ready_o,
    input  logic [DATA_W-1:0] ch2_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [1:0]        m_src_o,
    input  logic              clear_i,
    output logic [CNT_W-1:0]  ch0_cnt_o,
    output logic [CNT_W-1:0]  ch1_cnt_o,
    output logic [CNT_W-1:0]  ch2_cnt_o
);

    // Last granted channel resets to 2 so channel 0 is searched first.
    localparam logic [1:0] c_last_init = 2'd2;

    logic [2:0]        w_valid;
    logic [2:0]        w_grant;
    logic [2:0]        w_ready;
    logic [2:0]        w_accept;
    logic              w_can_load;
    logic [1:0]        w_sel;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [1:0]        r_m_src;
    logic [1:0]        r_last_grant;
    logic [CNT_W-1:0]  r_cnt [3];

    assign w_valid    = {ch2_valid_i, ch1_valid_i, ch0_valid_i};
    // Slot is loadable when empty or being drained this same cycle.
    assign w_can_load = ~r_m_valid | m_ready_i;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_grant = 3'b000;
        case (r_last_grant)
            2'd0: begin
                if      (w_valid[1]) w_grant = 3'b010;
                else if (w_valid[2]) w_grant = 3'b100;
                else if (w_valid[0]) w_grant = 3'b001;
            end
            2'd1: begin
                if      (w_valid[2]) w_grant = 3'b100;
                else if (w_valid[0]) w_grant = 3'b001;
                else if (w_valid[1]) w_grant = 3'b010;
            end
            default: begin
                if      (w_valid[0]) w_grant = 3'b001;
                else if (w_valid[1]) w_grant = 3'b010;
                else if (w_valid[2]) w_grant = 3'b100;
            end
        endcase
    end

    // Readies are forced low while reset is held, independent of the clock.
    assign w_ready  = w_grant & {3{w_can_load & rst_n}};
    assign w_accept = w_valid & w_ready;

    assign ch0_ready_o = w_ready[0];
    assign ch1_ready_o = w_ready[1];
    assign ch2_ready_o = w_ready[2];

    // Mux the accepted channel's index and byte (one-hot accept).
    always_comb begin
        w_sel      = 2'd0;
        w_sel_data = ch0_data_i;
        if (w_accept[1]) begin
            w_sel      = 2'd1;
            w_sel_data = ch1_data_i;
        end else if (w_accept[2]) begin
            w_sel      = 2'd2;
            w_sel_data = ch2_data_i;
        end
    end

    // Output slot and arbitration pointer: load on accept, empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_src      <= 2'd0;
            r_last_grant <= c_last_init;
        end else if (|w_accept) begin
            r_m_valid    <= 1'b1;
            r_m_data     <= w_sel_data;
            r_m_src      <= w_sel;
            r_last_grant <= w_sel;
        end else if (r_m_valid && m_ready_i) begin
            r_m_valid    <= 1'b0;
        end
    end

    // Per-channel accepted-byte counters; a coincident accept survives clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) r_cnt[n] <= '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (clear_i)
                    r_cnt[n] <= w_accept[n] ? CNT_W'(1) : '0;
                else if (w_accept[n])
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
            end
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_m_data;
    assign m_src_o   = r_m_src;
    assign ch0_cnt_o = r_cnt[0];
    assign ch1_cnt_o = r_cnt[1];
    assign ch2_cnt_o = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_stream_merge
//  Brief    : Directed self-checking bench for rr_stream_merge (CNT_W = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_merge;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ch0_valid_i, ch1_valid_i, ch2_valid_i;
    logic              ch0_ready_o, ch1_ready_o, ch2_ready_o;
    logic [DATA_W-1:0] ch0_data_i, ch1_data_i, ch2_data_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_o;
    logic [1:0]        m_src_o;
    logic              clear_i;
    logic [CNT_W-1:0]  ch0_cnt_o, ch1_cnt_o, ch2_cnt_o;

    int tests  = 0;
    int failed = 0;

    rr_stream_merge #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_valid_i(ch0_valid_i), .ch0_ready_o(ch0_ready_o), .ch0_data_i(ch0_data_i),
        .ch1_valid_i(ch1_valid_i), .ch1_ready_o(ch1_ready_o), .ch1_data_i(ch1_data_i),
        .ch2_valid_i(ch2_valid_i), .ch2_ready_o(ch2_ready_o), .ch2_data_i(ch2_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_src_o(m_src_o), .clear_i(clear_i),
        .ch0_cnt_o(ch0_cnt_o), .ch1_cnt_o(ch1_cnt_o), .ch2_cnt_o(ch2_cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch0_valid_i = 0; ch1_valid_i = 0; ch2_valid_i = 0;
        ch0_data_i = '0; ch1_data_i = '0; ch2_data_i = '0;
        m_ready_i = 0; clear_i = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        ch0_valid_i = 1;
        #2;
        tests++;
        if ({ch2_ready_o, ch1_ready_o, ch0_ready_o} !== 3'b000) begin
            failed++;
            $display("FAIL reset_ready got %b exp 000", {ch2_ready_o, ch1_ready_o, ch0_ready_o});
        end
        ch0_valid_i = 0;
        tick();
        rst_n = 1;
        repeat (5) tick();
        tests++;
        if (m_valid_o !== 1'b0 || m_data_o !== 8'h00 || m_src_o !== 2'd0) begin
            failed++;
            $display("FAIL reset_slot got v=%b d=%h s=%0d exp v=0 d=00 s=0", m_valid_o, m_data_o, m_src_o);
        end
        tests++;
        if ({ch2_ready_o, ch1_ready_o, ch0_ready_o} !== 3'b000) begin
            failed++;
            $display("FAIL idle_ready got %b exp 000", {ch2_ready_o, ch1_ready_o, ch0_ready_o});
        end
        tests++;
        if (ch0_cnt_o !== 4'd0 || ch1_cnt_o !== 4'd0 || ch2_cnt_o !== 4'd0) begin
            failed++;
            $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", ch0_cnt_o, ch1_cnt_o, ch2_cnt_o);
        end
    endtask

    task automatic test_single_stream();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        apply_reset();
        m_ready_i = 1;
        ch1_valid_i = 1;
        ch1_data_i = bytes[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) ch1_data_i = bytes[i+1];
            else ch1_valid_i = 0;
            tests++;
            if (m_valid_o !== 1'b1 || m_data_o !== bytes[i] || m_src_o !== 2'd1) begin
                failed++;
                $display("FAIL single_beat%0d got v=%b d=%h s=%0d exp v=1 d=%h s=1",
                         i, m_valid_o, m_data_o, m_src_o, bytes[i]);
            end
        end
        tests++;
        if (ch1_cnt_o !== 4'd3 || ch0_cnt_o !== 4'd0 || ch2_cnt_o !== 4'd0) begin
            failed++;
            $display("FAIL single_cnt got %0d/%0d/%0d exp 0/3/0", ch0_cnt_o, ch1_cnt_o, ch2_cnt_o);
        end
        tick();
        tests++;
        if (m_valid_o !== 1'b0) begin
            failed++;
            $display("FAIL single_drain got v=%b exp 0", m_valid_o);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src;
        logic [7:0] exp_data;
        logic [7:0] base [3];
        base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0;
        apply_reset();
        m_ready_i = 1;
        ch0_valid_i = 1; ch0_data_i = base[0];
        ch1_valid_i = 1; ch1_data_i = base[1];
        ch2_valid_i = 1; ch2_data_i = base[2];
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if ((ch0_ready_o + ch1_ready_o + ch2_ready_o) != 1) begin
                failed++;
                $display("FAIL rr_onehot_ready%0d got %b exp one hot", i,
                         {ch2_ready_o, ch1_ready_o, ch0_ready_o});
            end
            tick();
            exp_src  = 2'(i % 3);
            exp_data = base[i % 3];
            tests++;
            if (m_valid_o !== 1'b1 || m_src_o !== exp_src || m_data_o !== exp_data) begin
                failed++;
                $display("FAIL rr_grant%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         i, m_valid_o, m_src_o, m_data_o, exp_src, exp_data);
            end
        end
        idle_inputs();
        tests++;
        if (ch0_cnt_o !== 4'd2 || ch1_cnt_o !== 4'd2 || ch2_cnt_o !== 4'd2) begin
            failed++;
            $display("FAIL rr_cnt got %0d/%0d/%0d exp 2/2/2", ch0_cnt_o, ch1_cnt_o, ch2_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        m_ready_i = 0;
        ch2_valid_i = 1; ch2_data_i = 8'h5A;
        tick();
        ch2_valid_i = 0;
        ch0_valid_i = 1; ch0_data_i = 8'h99;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (m_valid_o !== 1'b1 || m_data_o !== 8'h5A || m_src_o !== 2'd2 ||
                {ch2_ready_o, ch1_ready_o, ch0_ready_o} !== 3'b000) begin
                failed++;
                $display("FAIL stall%0d got v=%b d=%h s=%0d rdy=%b exp v=1 d=5a s=2 rdy=000",
                         i, m_valid_o, m_data_o, m_src_o, {ch2_ready_o, ch1_ready_o, ch0_ready_o});
            end
            tick();
        end
        ch0_valid_i = 0;
        m_ready_i = 1;
        tick();
        m_ready_i = 0;
        tests++;
        if (m_valid_o !== 1'b0 || m_data_o !== 8'h5A || m_src_o !== 2'd2) begin
            failed++;
            $display("FAIL drain got v=%b d=%h s=%0d exp v=0 d=5a s=2", m_valid_o, m_data_o, m_src_o);
        end
        tests++;
        if (ch0_cnt_o !== 4'd0 || ch1_cnt_o !== 4'd0 || ch2_cnt_o !== 4'd1) begin
            failed++;
            $display("FAIL stall_cnt got %0d/%0d/%0d exp 0/0/1", ch0_cnt_o, ch1_cnt_o, ch2_cnt_o);
        end
    endtask

    task automatic test_wrap_clear();
        apply_reset();
        m_ready_i = 1;
        ch0_valid_i = 1;
        for (int i = 0; i < 17; i++) begin
            ch0_data_i = 8'(i + 1);
            tick();
        end
        ch0_valid_i = 0;
        tests++;
        if (ch0_cnt_o !== 4'd1 || m_data_o !== 8'd17) begin
            failed++;
            $display("FAIL wrap got cnt=%0d d=%h exp cnt=1 d=11", ch0_cnt_o, m_data_o);
        end
        ch1_valid_i = 1; ch1_data_i = 8'h42;
        tick();
        ch1_valid_i = 0;
        tests++;
        if (ch1_cnt_o !== 4'd1) begin
            failed++;
            $display("FAIL pre_clear_cnt1 got %0d exp 1", ch1_cnt_o);
        end
        ch0_valid_i = 1; ch0_data_i = 8'h55;
        clear_i = 1;
        tick();
        ch0_valid_i = 0;
        clear_i = 0;
        tests++;
        if (ch0_cnt_o !== 4'd1 || ch1_cnt_o !== 4'd0 || ch2_cnt_o !== 4'd0) begin
            failed++;
            $display("FAIL clear_accept got %0d/%0d/%0d exp 1/0/0", ch0_cnt_o, ch1_cnt_o, ch2_cnt_o);
        end
        clear_i = 1;
        tick();
        clear_i = 0;
        tests++;
        if (ch0_cnt_o !== 4'd0) begin
            failed++;
            $display("FAIL clear_plain got %0d exp 0", ch0_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_ready_i = 0;
        ch1_valid_i = 1; ch1_data_i = 8'h77;
        tick();
        ch1_valid_i = 0;
        tests++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'h77) begin
            failed++;
            $display("FAIL mid_load got v=%b d=%h exp v=1 d=77", m_valid_o, m_data_o);
        end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (m_valid_o !== 1'b0 || m_data_o !== 8'h00 || ch1_cnt_o !== 4'd0) begin
            failed++;
            $display("FAIL mid_reset got v=%b d=%h c1=%0d exp v=0 d=00 c1=0", m_valid_o, m_data_o, ch1_cnt_o);
        end
        tick();
        rst_n = 1;
        m_ready_i = 1;
        ch0_valid_i = 1; ch0_data_i = 8'h01;
        ch2_valid_i = 1; ch2_data_i = 8'h02;
        tick();
        idle_inputs();
        tests++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'h01 || m_src_o !== 2'd0) begin
            failed++;
            $display("FAIL post_reset_prio got v=%b d=%h s=%0d exp v=1 d=01 s=0", m_valid_o, m_data_o, m_src_o);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_wrap_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_stream_merge.md
Name: rr_stream_merge

Overview:
Three-input round-robin merge stage feeding a single 8-bit valid/ready stream. It collects bytes from three independent producer channels (default, kelvin and art traffic). It forwards them through one registered output slot tagged with the source channel index. Per-channel wrapping byte counters provide observability for scoreboards and debug.

Parameters:
DATA_W, 8, width of every data bus
CNT_W, 16, width of each per-channel accepted-byte counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
ch0_valid_i  input  1  channel 0 byte valid
ch0_ready_o  output  1  channel 0 byte accepted this cycle when high with valid
ch0_data_i  input  DATA_W  channel 0 byte
ch1_valid_i / ch1_ready_o / ch1_data_i  same as channel 0, channel 1
ch2_valid_i / ch2_ready_o / ch2_data_i  same as channel 0, channel 2
m_valid_o  output  1  output slot holds a byte
m_ready_i  input  1  downstream accepts byte
m_data_o  output  DATA_W  forwarded byte
m_src_o  output  2  source channel of m_data_o (0,1,2; 3 never driven)
clear_i  input  1  synchronous clear of all counters
ch0_cnt_o, ch1_cnt_o, ch2_cnt_o  output  CNT_W  bytes accepted per channel, wrapping

Behaviour:
- Reset (rst_n low, asynchronous): m_valid_o=0, m_data_o=0, m_src_o=0, all cnt=0, last_grant=2 so channel 0 has first priority. ch*_ready_o evaluate to 0 while in reset.
- can_load = ~m_valid_o | m_ready_i. The output slot is loadable when empty or draining in the same cycle.
- Arbitration (combinational): search order starts at (last_grant+1) mod 3 and wraps: 0,1,2,0,... The first channel with valid high wins grant. No valid means no grant.
- chN_ready_o = can_load & grant[N]. At most one ready is high per cycle. A ready may depend on valids; a valid must never depend on ready.
- Accept (chN_valid_i & chN_ready_o) at an edge:
  - m_data_o <= chN_data_i, m_src_o <= N, m_valid_o <= 1.
  - last_grant <= N.
  - cntN <= cntN+1, wrapping from 2^CNT_W-1 to 0.
- No accept but m_valid_o & m_ready_i: m_valid_o <= 0. m_data_o and m_src_o hold their last values.
- Stall (m_valid_o & ~m_ready_i): m_data_o and m_src_o stay stable, all ch*_ready_o are 0, last_grant is unchanged.
- Latency is 1 cycle from input accept to m_valid_o. Throughput is 1 byte per cycle sustained with m_ready_i held high (simultaneous drain and load).
- Fairness: with all three valid held continuously and m_ready_i=1, grants rotate 0,1,2,0,... Each channel waits at most 2 accepts of other channels.
- last_grant updates only on an accept. A dropped request does not rotate priority.
- clear_i: all counters become 0 at the edge. If an accept on channel N coincides with clear_i, cntN becomes 1 and the other counters become 0.
- Reset asserted mid-transfer drops any byte held in the slot and aborts it. No partial state survives reset.
- The block never duplicates or drops an accepted byte. Per-channel order is preserved.

Test Plan:
- Reset then idle: no valids for 5 cycles -> m_valid_o=0, all ready=0, all cnt=0.
- Single channel stream: ch1 sends 0x11,0x22,0x33 back-to-back with m_ready_i=1 -> m_data_o shows 0x11,0x22,0x33 on consecutive cycles, m_src_o=1 each, ch1_cnt_o=3.
- Round-robin: all channels valid with ch0=0xA0, ch1=0xB0, ch2=0xC0, m_ready_i=1, 6 cycles -> m_src_o sequence 0,1,2,0,1,2, each cnt=2.
- Backpressure: ch2 sends 0x5A, m_ready_i=0 for 4 cycles -> m_data_o=0x5A and m_src_o=2 stay stable, all ready=0, then 1 cycle of m_ready_i=1 drains the slot and m_valid_o=0 next cycle.
- Counter wrap and clear:
  - With CNT_W=4, ch0 sends 17 bytes -> ch0_cnt_o=1.
  - clear_i asserted in the same cycle as a ch0 accept -> ch0_cnt_o=1, others 0.
- Reset mid-operation: assert rst_n=0 while m_valid_o=1 holding 0x77 -> m_valid_o=0 immediately. After release, a new ch0 byte 0x01 is output with m_src_o=0 (priority restarted at channel 0).
